frame_window_ctrl: RTL and testbench
====================================

FRAME_WINDOW_CTRL -- requirements
Module: frame_window_ctrl

Interface
REQ-001 Parameter MAXMISS, default 3: number of consecutive frame overruns that triggers escalation (range 1..7).
REQ-002 Parameter SYSRST_W, default 4: SYSRST pulse width in CLK cycles (range 1..15).
REQ-003 Parameter DEFLEN, default 8'h06: FWLEN value after reset.
REQ-004 CLK  in  1  single system clock; all logic on rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 EN  in  1  supervision enable; level-sensitive.
REQ-007 CFGLEN  in  8  requested window length.
REQ-008 CFGLD  in  1  one-cycle strobe that captures CFGLEN into the shadow register.
REQ-009 SVCREQ  in  1  software service kick; level, sampled each cycle.
REQ-010 FWOVR  in  1  overrun flag from frame_window.
REQ-011 FWLEN  out  8  active window length driven to frame_window.
REQ-012 WDRST  out  1  reset to frame_window.
REQ-013 WDSRVC  out  1  service pulse to frame_window.
REQ-014 FAULT  out  1  overrun indication.
REQ-015 SYSRST  out  1  escalation reset.
REQ-016 MISSCNT  out  3  current consecutive-overrun count.

Function
REQ-017 FSM states: IDLE, ARM, RUN, SVC, MISS, ESC; all outputs registered.
REQ-018 IDLE: WDRST=1; exit to ARM on the first cycle EN=1.
REQ-019 ARM (1 cycle): WDRST=1; FWLEN loaded from shadow; next state RUN.
REQ-020 RUN: WDRST=0; FWOVR=1 -> MISS; else SVCREQ=1 -> SVC; else stay.
REQ-021 SVC (1 cycle): WDSRVC=1; MISSCNT cleared to 0; next state RUN.
REQ-022 SVCREQ held high yields one WDSRVC pulse per rising edge of SVCREQ (edge-detected), never back-to-back.
REQ-023 MISS (1 cycle): FAULT=1; MISSCNT incremented, saturating at 7.
REQ-024 MISS exit: to ESC if the new MISSCNT >= MAXMISS, else to ARM (re-arm the window).
REQ-025 ESC: SYSRST=1 for exactly SYSRST_W cycles; MISSCNT cleared on exit; then IDLE.
REQ-026 FWOVR and SVCREQ both asserted in the same RUN cycle: the overrun wins; no WDSRVC is issued.
REQ-027 EN=0 in any state except ESC: next state IDLE; WDRST=1 the following cycle. ESC always completes.
REQ-028 CFGLD: captures CFGLEN into the shadow register in any state; a value of 0 is ignored and the shadow keeps its old value.
REQ-029 A new shadow value reaches FWLEN only at the next ARM; it never changes during RUN.
REQ-030 CFGLD and ARM in the same cycle: ARM loads the new CFGLEN.

Reset
REQ-031 With RST=1 (asynchronous): state=IDLE, FWLEN=DEFLEN, shadow=DEFLEN, WDRST=1, WDSRVC=0, FAULT=0, SYSRST=0, MISSCNT=0.
REQ-032 Deassertion of RST is synchronous-safe: the first transition out of IDLE occurs no earlier than the first CLK edge after RST falls.

Configuration
REQ-033 Macro FWCTRL_STICKY_FAULT_EN.
REQ-034 Macro defined: FAULT sets in MISS and stays 1 until EN=0, CFGLD, or RST.
REQ-035 Macro undefined: FAULT is a one-cycle pulse in MISS only.

Verification
REQ-036 Reset, then EN=1 -> WDRST stays 1 for IDLE+ARM and falls on the 2nd edge after EN; FWLEN=8'h06.
REQ-037 RUN with SVCREQ pulsed 1 cycle -> WDSRVC=1 for exactly 1 cycle, 1 cycle later; MISSCNT=0; no FAULT.
REQ-038 MAXMISS=3: three FWOVR events without service -> MISSCNT 1,2,3, each with a FAULT pulse and a re-arm (WDRST 1 cycle) for the first two; after the third, SYSRST=1 for 4 cycles, then IDLE with MISSCNT=0.
REQ-039 FWOVR and SVCREQ in the same cycle -> MISS taken, WDSRVC stays 0, MISSCNT increments.
REQ-040 CFGLEN=8'h0A with CFGLD during RUN -> FWLEN stays 8'h06 until the next ARM, then 8'h0A; CFGLEN=0 with CFGLD -> FWLEN unchanged.
REQ-041 EN dropped mid-RUN -> IDLE, WDRST=1 the next cycle; with FWCTRL_STICKY_FAULT_EN defined, a prior FAULT clears at the same time.

Source files
------------

// File: rtl/frame_window_ctrl_if.sv
// frame_window_ctrl_if: control/status bundle between the supervisor and its software/window side.
interface frame_window_ctrl_if;
  logic       en;
  logic [7:0] cfglen;
  logic       cfgld;
  logic       svcreq;
  logic       fwovr;
  logic [7:0] fwlen;
  logic       wdrst;
  logic       wdsrvc;
  logic       fault;
  logic       sysrst;
  logic [2:0] misscnt;
  modport master (output en, cfglen, cfgld, svcreq, fwovr,
                  input  fwlen, wdrst, wdsrvc, fault, sysrst, misscnt);
  modport slave  (input  en, cfglen, cfgld, svcreq, fwovr,
                  output fwlen, wdrst, wdsrvc, fault, sysrst, misscnt);
endinterface

// File: rtl/frame_window_ctrl.sv
// frame_window_ctrl: supervises a frame window, counts overruns and escalates to a system reset.
// Define FWCTRL_STICKY_FAULT_EN to make FAULT sticky until EN=0, CFGLD or reset.
module frame_window_ctrl #(
  parameter int         MAXMISS  = 3,
  parameter int         SYSRST_W = 4,
  parameter logic [7:0] DEFLEN   = 8'h06
) (
  input logic           clk,
  input logic           rst,
  frame_window_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, RUN, SVC, MISS, ESC} state_t;
  state_t     state, nxt;
  logic [7:0] shadow;
  logic       svc_prev;
  logic [3:0] esc_cnt;
  logic       cfg_ok;
  logic       svc_rise;
  assign cfg_ok   = bus.cfgld && (bus.cfglen != 8'd0);
  assign svc_rise = bus.svcreq && !svc_prev;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.en ? ARM : IDLE;
      ARM:     nxt = RUN;
      RUN:     nxt = bus.fwovr ? MISS : svc_rise ? SVC : RUN;
      SVC:     nxt = RUN;
      MISS:    nxt = (int'(bus.misscnt) >= MAXMISS) ? ESC : ARM;
      ESC:     nxt = (esc_cnt == 4'(SYSRST_W - 1)) ? IDLE : ESC;
      default: nxt = IDLE;
    endcase
    if (!bus.en && state != ESC) nxt = IDLE;
  end
  // outputs are registered decodes of the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= DEFLEN;
      svc_prev    <= 1'b0;
      esc_cnt     <= 4'd0;
      bus.fwlen   <= DEFLEN;
      bus.wdrst   <= 1'b1;
      bus.wdsrvc  <= 1'b0;
      bus.fault   <= 1'b0;
      bus.sysrst  <= 1'b0;
      bus.misscnt <= 3'd0;
    end else begin
      state      <= nxt;
      svc_prev   <= bus.svcreq;
      esc_cnt    <= (state == ESC) ? esc_cnt + 4'd1 : 4'd0;
      if (cfg_ok) shadow <= bus.cfglen;
      if (state == ARM) bus.fwlen <= cfg_ok ? bus.cfglen : shadow;
      bus.wdrst  <= (nxt == IDLE) || (nxt == ARM) || (nxt == ESC);
      bus.wdsrvc <= (nxt == SVC);
      bus.sysrst <= (nxt == ESC);
      bus.misscnt <= (nxt == MISS) ? ((bus.misscnt == 3'd7) ? 3'd7 : bus.misscnt + 3'd1) :
                     ((nxt == SVC) || (state == ESC && nxt != ESC)) ? 3'd0 : bus.misscnt;
`ifdef FWCTRL_STICKY_FAULT_EN
      bus.fault  <= (nxt == MISS) || (bus.fault && bus.en && !bus.cfgld);
`else
      bus.fault  <= (nxt == MISS);
`endif
    end
  end
endmodule

// File: tb/tb_frame_window_ctrl.sv
// tb_frame_window_ctrl: table-driven directed check of frame_window_ctrl (default build, default parameters).
module tb_frame_window_ctrl;
  typedef struct {
    logic        en;
    logic [7:0]  cfglen;
    logic        cfgld;
    logic        svcreq;
    logic        fwovr;
    logic [14:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  frame_window_ctrl_if bus();
  frame_window_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  // exp packs {fwlen, wdrst, wdsrvc, fault, sysrst, misscnt}
  function automatic vec_t v(logic en, logic [7:0] cfglen, logic cfgld, logic svc, logic ovr,
                             logic [7:0] fwlen, logic wdrst, logic wdsrvc, logic fault,
                             logic sysrst, logic [2:0] miss);
    vec_t r;
    r.en = en; r.cfglen = cfglen; r.cfgld = cfgld; r.svcreq = svc; r.fwovr = ovr;
    r.exp = {fwlen, wdrst, wdsrvc, fault, sysrst, miss};
    return r;
  endfunction
  task automatic check(string name, logic [14:0] exp);
    logic [14:0] act;
    act = {bus.fwlen, bus.wdrst, bus.wdsrvc, bus.fault, bus.sysrst, bus.misscnt};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got fwlen/wdrst/wdsrvc/fault/sysrst/miss=%h expected %h", name, act, exp);
    end
  endtask
  task automatic apply(vec_t t, string name);
    bus.en = t.en; bus.cfglen = t.cfglen; bus.cfgld = t.cfgld;
    bus.svcreq = t.svcreq; bus.fwovr = t.fwovr;
    @(posedge clk); #1;
    check(name, t.exp);
  endtask
  initial begin
    //                en cfglen cfgld svc ovr  fwlen  wdrst srvc flt sys miss
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h06, 1, 0, 0, 0, 3'd0)); // ARM
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h06, 0, 0, 0, 0, 3'd0)); // RUN
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h06, 0, 0, 0, 0, 3'd0));
    tbl.push_back(v(1, 8'h00, 0, 1, 0, 8'h06, 0, 1, 0, 0, 3'd0)); // SVC
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h06, 0, 0, 0, 0, 3'd0));
    tbl.push_back(v(1, 8'h00, 0, 1, 0, 8'h06, 0, 1, 0, 0, 3'd0)); // held svcreq
    tbl.push_back(v(1, 8'h00, 0, 1, 0, 8'h06, 0, 0, 0, 0, 3'd0));
    tbl.push_back(v(1, 8'h00, 0, 1, 0, 8'h06, 0, 0, 0, 0, 3'd0));
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h06, 0, 0, 0, 0, 3'd0));
    tbl.push_back(v(1, 8'h0A, 1, 0, 0, 8'h06, 0, 0, 0, 0, 3'd0)); // load shadow in RUN
    tbl.push_back(v(1, 8'h00, 0, 0, 1, 8'h06, 0, 0, 1, 0, 3'd1)); // MISS 1
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h06, 1, 0, 0, 0, 3'd1)); // re-ARM
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h0A, 0, 0, 0, 0, 3'd1)); // new length
    tbl.push_back(v(1, 8'h00, 1, 0, 0, 8'h0A, 0, 0, 0, 0, 3'd1)); // zero ignored
    tbl.push_back(v(1, 8'h00, 0, 1, 1, 8'h0A, 0, 0, 1, 0, 3'd2)); // overrun beats service
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0, 3'd2));
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h0A, 0, 0, 0, 0, 3'd2));
    tbl.push_back(v(1, 8'h00, 0, 0, 1, 8'h0A, 0, 0, 1, 0, 3'd3)); // MISS 3
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 1, 3'd3)); // ESC x4
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 1, 3'd3));
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 1, 3'd3));
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 1, 3'd3));
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0, 3'd0)); // IDLE
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0, 3'd0)); // ARM
    tbl.push_back(v(1, 8'h00, 0, 0, 0, 8'h0A, 0, 0, 0, 0, 3'd0)); // RUN
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0, 3'd0)); // EN drop
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0, 3'd0));
    bus.en = 1'b0; bus.cfglen = 8'h00; bus.cfgld = 1'b0; bus.svcreq = 1'b0; bus.fwovr = 1'b0;
    @(posedge clk); #1;
    check("reset", {8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
    rst = 1'b0;
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    // escalation must complete even with EN low
    apply(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0, 3'd0), "esc_arm");
    for (int k = 1; k <= 3; k++) begin
      apply(v(1, 8'h00, 0, 0, 0, 8'h0A, 0, 0, 0, 0, 3'(k - 1)), $sformatf("esc_run%0d", k));
      apply(v(1, 8'h00, 0, 0, 1, 8'h0A, 0, 0, 1, 0, 3'(k)), $sformatf("esc_miss%0d", k));
      if (k < 3) apply(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0, 3'(k)), $sformatf("esc_rearm%0d", k));
    end
    apply(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 1, 3'd3), "esc_enter");
    for (int k = 0; k < 3; k++) apply(v(0, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 1, 3'd3), $sformatf("esc_hold%0d", k));
    apply(v(0, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0, 3'd0), "esc_exit");
    // CFGLD coinciding with ARM takes the new value directly
    apply(v(1, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0, 3'd0), "arm_ld_arm");
    apply(v(1, 8'h33, 1, 0, 0, 8'h33, 0, 0, 0, 0, 3'd0), "arm_ld_run");
    apply(v(1, 8'h00, 0, 0, 0, 8'h33, 0, 0, 0, 0, 3'd0), "arm_ld_keep");
    // asynchronous reset without a clock edge, then held across an edge
    #2 rst = 1'b1;
    #1 check("async_rst", {8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
    @(posedge clk); #1;
    check("rst_hold", {8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
    rst = 1'b0;
    apply(v(1, 8'h00, 0, 0, 0, 8'h06, 1, 0, 0, 0, 3'd0), "post_rst_arm");
    apply(v(1, 8'h00, 0, 0, 0, 8'h06, 0, 0, 0, 0, 3'd0), "post_rst_run");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
